// File: rtl/p601_sysctl.sv
// p601zero system controller: CPU clock divider, CPU reset sequencer with
// soft-reset re-entry, periodic interrupt timers with pending/mask/ack/overrun,
// and the 7-segment digit-power multiplex strobes.
module p601_sysctl #(
    parameter int unsigned                   CPU_DIV    = 3,
    parameter int unsigned                   RES_CYCLES = 4,
    parameter int unsigned                   NUM_IRQ    = 2,
    parameter logic [32*NUM_IRQ-1:0]         IRQ_DIV    = {32'd12000, 32'd240000},
    parameter int unsigned                   MUX_DIV    = 2
) (
    input  logic               clk_in,
    input  logic               b_reset,
    input  logic               soft_rst,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [NUM_IRQ-1:0] irq_ack,
    output logic               sys_clk,
    output logic               sys_clk_rise,
    output logic               sys_res,
    output logic [NUM_IRQ-1:0] irq_pend,
    output logic [NUM_IRQ-1:0] irq_ovr,
    output logic               sys_irq,
    output logic               led_pow_h,
    output logic               led_pow_l
);

    // Largest timer period across all channels, used to size the shared counter width.
    function automatic longint unsigned max_div();
        longint unsigned m;
        m = 64'd2;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (64'(IRQ_DIV[32*i +: 32]) > m) begin
                m = 64'(IRQ_DIV[32*i +: 32]);
            end
        end
        return m;
    endfunction

    localparam int DW = $clog2(CPU_DIV + 1);
    localparam int RW = $clog2(RES_CYCLES + 1);
    localparam int MW = $clog2(MUX_DIV + 1);
    localparam int TW = $clog2(max_div() + 64'd1);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        RUN   = 2'd2
    } rst_state_t;

    rst_state_t         state_r;
    logic [DW-1:0]      div_cnt_r;
    logic               sys_clk_r;
    logic               sys_clk_rise_r;
    logic [RW-1:0]      res_cnt_r;
    logic               sys_res_r;
    logic [TW-1:0]      tmr_r [NUM_IRQ];
    logic [NUM_IRQ-1:0] pend_r;
    logic [NUM_IRQ-1:0] ovr_r;
    logic               sys_irq_r;
    logic [MW-1:0]      mux_cnt_r;
    logic               led_h_r;
    logic               led_l_r;

    logic               div_wrap_s;
    logic               rise_s;
    logic               soft_accept_s;
    logic [NUM_IRQ-1:0] tick_s;

    // Divider wrap, the sys_clk 0->1 edge, and an accepted soft reset request.
    always_comb begin
        div_wrap_s    = (div_cnt_r == DW'(CPU_DIV - 1));
        rise_s        = div_wrap_s && !sys_clk_r;
        soft_accept_s = (state_r == RUN) && soft_rst;
    end

    // Per-channel tick on the last count of each timer period.
    always_comb begin
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            tick_s[i] = (tmr_r[i] == TW'(IRQ_DIV[32*i +: 32] - 32'd1));
        end
    end

    // Free-running CPU clock divider; soft reset never disturbs it.
    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            div_cnt_r      <= '0;
            sys_clk_r      <= 1'b0;
            sys_clk_rise_r <= 1'b0;
        end else if (div_wrap_s) begin
            div_cnt_r      <= '0;
            sys_clk_r      <= ~sys_clk_r;
            sys_clk_rise_r <= ~sys_clk_r;
        end else begin
            div_cnt_r      <= div_cnt_r + DW'(1);
            sys_clk_rise_r <= 1'b0;
        end
    end

    // CPU reset sequencer: hold, count sys_clk rises, run until a soft reset re-enters.
    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            state_r   <= HOLD;
            res_cnt_r <= '0;
            sys_res_r <= 1'b1;
        end else begin
            case (state_r)
                HOLD: begin
                    state_r   <= COUNT;
                    res_cnt_r <= RW'(RES_CYCLES);
                    sys_res_r <= 1'b1;
                end
                COUNT: begin
                    if (rise_s) begin
                        res_cnt_r <= res_cnt_r - RW'(1);
                        if (res_cnt_r == RW'(1)) begin
                            sys_res_r <= 1'b0;
                            state_r   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (soft_rst) begin
                        sys_res_r <= 1'b1;
                        res_cnt_r <= RW'(RES_CYCLES);
                        state_r   <= COUNT;
                    end
                end
                default: begin
                    state_r   <= HOLD;
                    res_cnt_r <= '0;
                    sys_res_r <= 1'b1;
                end
            endcase
        end
    end

    // Periodic timers with pending/overrun; a tick beats a same-cycle ack for pending.
    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                tmr_r[i] <= '0;
            end
            pend_r <= '0;
            ovr_r  <= '0;
        end else if (sys_res_r || soft_accept_s) begin
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                tmr_r[i] <= '0;
            end
            pend_r <= '0;
            ovr_r  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                if (tick_s[i]) begin
                    tmr_r[i]  <= '0;
                    pend_r[i] <= 1'b1;
                    if (irq_ack[i]) begin
                        ovr_r[i] <= 1'b0;
                    end else if (pend_r[i]) begin
                        ovr_r[i] <= 1'b1;
                    end else begin
                        ovr_r[i] <= ovr_r[i];
                    end
                end else begin
                    tmr_r[i] <= tmr_r[i] + TW'(1);
                    if (irq_ack[i]) begin
                        pend_r[i] <= 1'b0;
                        ovr_r[i]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Masked interrupt summary, one cycle behind pending/mask.
    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            sys_irq_r <= 1'b0;
        end else begin
            sys_irq_r <= |(pend_r & irq_mask);
        end
    end

    // Digit-power multiplex strobes, running regardless of CPU reset.
    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            mux_cnt_r <= '0;
            led_h_r   <= 1'b0;
            led_l_r   <= 1'b1;
        end else if (mux_cnt_r == MW'(MUX_DIV - 1)) begin
            mux_cnt_r <= '0;
            led_h_r   <= ~led_h_r;
            led_l_r   <= led_h_r;
        end else begin
            mux_cnt_r <= mux_cnt_r + MW'(1);
        end
    end

    assign sys_clk      = sys_clk_r;
    assign sys_clk_rise = sys_clk_rise_r;
    assign sys_res      = sys_res_r;
    assign irq_pend     = pend_r;
    assign irq_ovr      = ovr_r;
    assign sys_irq      = sys_irq_r;
    assign led_pow_h    = led_h_r;
    assign led_pow_l    = led_l_r;

endmodule

// File: tb/tb_p601_sysctl.sv
// Directed bench for p601_sysctl with small dividers so every phase is reachable quickly.
module tb_p601_sysctl;

    logic       clk_in;
    logic       b_reset;
    logic       soft_rst;
    logic [1:0] irq_mask;
    logic [1:0] irq_ack;
    logic       sys_clk;
    logic       sys_clk_rise;
    logic       sys_res;
    logic [1:0] irq_pend;
    logic [1:0] irq_ovr;
    logic       sys_irq;
    logic       led_pow_h;
    logic       led_pow_l;

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;   // clk_in edges since the last b_reset release

    p601_sysctl #(
        .CPU_DIV    (3),
        .RES_CYCLES (4),
        .NUM_IRQ    (2),
        .IRQ_DIV    ({32'd5, 32'd8}),
        .MUX_DIV    (2)
    ) dut (
        .clk_in       (clk_in),
        .b_reset      (b_reset),
        .soft_rst     (soft_rst),
        .irq_mask     (irq_mask),
        .irq_ack      (irq_ack),
        .sys_clk      (sys_clk),
        .sys_clk_rise (sys_clk_rise),
        .sys_res      (sys_res),
        .irq_pend     (irq_pend),
        .irq_ovr      (irq_ovr),
        .sys_irq      (sys_irq),
        .led_pow_h    (led_pow_h),
        .led_pow_l    (led_pow_l)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
        ecnt++;
    endtask

    task automatic goto_edge(input int e);
        while (ecnt < e) step();
    endtask

    task automatic release_reset();
        b_reset = 1'b1;
        ecnt    = 0;
    endtask

    task automatic test_reset();
        b_reset  = 1'b0;
        soft_rst = 1'b0;
        irq_mask = 2'b01;
        irq_ack  = 2'b00;
        repeat (3) step();
        n_tests++; if (sys_clk !== 1'b0)      begin n_fail++; $display("FAIL reset_sys_clk: got %b expected 0", sys_clk); end
        n_tests++; if (sys_clk_rise !== 1'b0) begin n_fail++; $display("FAIL reset_rise: got %b expected 0", sys_clk_rise); end
        n_tests++; if (sys_res !== 1'b1)      begin n_fail++; $display("FAIL reset_sys_res: got %b expected 1", sys_res); end
        n_tests++; if (irq_pend !== 2'b00)    begin n_fail++; $display("FAIL reset_pend: got %b expected 00", irq_pend); end
        n_tests++; if (irq_ovr !== 2'b00)     begin n_fail++; $display("FAIL reset_ovr: got %b expected 00", irq_ovr); end
        n_tests++; if (sys_irq !== 1'b0)      begin n_fail++; $display("FAIL reset_sys_irq: got %b expected 0", sys_irq); end
        n_tests++; if (led_pow_h !== 1'b0)    begin n_fail++; $display("FAIL reset_led_h: got %b expected 0", led_pow_h); end
        n_tests++; if (led_pow_l !== 1'b1)    begin n_fail++; $display("FAIL reset_led_l: got %b expected 1", led_pow_l); end
    endtask

    // Release and follow n edges: sys_clk toggles every 3 edges, rise pulses on
    // edges 3, 9, 15..., sys_res falls at edge 21, led_pow_h toggles every 2 edges.
    task automatic test_release_seq(input int n);
        logic e_clk, e_rise, e_res, e_h;
        release_reset();
        for (int k = 1; k <= n; k++) begin
            step();
            e_clk  = ((k / 3) % 2) == 1;
            e_rise = ((k % 3) == 0) && (((k / 3) % 2) == 1);
            e_res  = (k < 21);
            e_h    = ((k / 2) % 2) == 1;
            n_tests++; if (sys_clk !== e_clk)       begin n_fail++; $display("FAIL seq_sys_clk@%0d: got %b expected %b", k, sys_clk, e_clk); end
            n_tests++; if (sys_clk_rise !== e_rise) begin n_fail++; $display("FAIL seq_rise@%0d: got %b expected %b", k, sys_clk_rise, e_rise); end
            n_tests++; if (sys_res !== e_res)       begin n_fail++; $display("FAIL seq_sys_res@%0d: got %b expected %b", k, sys_res, e_res); end
            n_tests++; if (led_pow_h !== e_h)       begin n_fail++; $display("FAIL seq_led_h@%0d: got %b expected %b", k, led_pow_h, e_h); end
            n_tests++; if (led_pow_l !== !e_h)      begin n_fail++; $display("FAIL seq_led_l@%0d: got %b expected %b", k, led_pow_l, !e_h); end
        end
    endtask

    // ch1 ticks at edges 26,31,36,41,46; ch0 ticks at 29,37,45 (timers start after edge 21).
    task automatic test_irq();
        goto_edge(25);
        n_tests++; if (irq_pend !== 2'b00) begin n_fail++; $display("FAIL irq_pend@25: got %b expected 00", irq_pend); end
        goto_edge(26);
        n_tests++; if (irq_pend !== 2'b10) begin n_fail++; $display("FAIL irq_pend@26: got %b expected 10", irq_pend); end
        goto_edge(27);
        n_tests++; if (sys_irq !== 1'b0)   begin n_fail++; $display("FAIL irq_masked@27: got %b expected 0", sys_irq); end
        goto_edge(29);
        n_tests++; if (irq_pend !== 2'b11) begin n_fail++; $display("FAIL irq_pend@29: got %b expected 11", irq_pend); end
        n_tests++; if (sys_irq !== 1'b0)   begin n_fail++; $display("FAIL irq_lag@29: got %b expected 0", sys_irq); end
        goto_edge(30);
        n_tests++; if (sys_irq !== 1'b1)   begin n_fail++; $display("FAIL irq_sys@30: got %b expected 1", sys_irq); end
    endtask

    task automatic test_ack_tick_collision();
        irq_ack = 2'b10;
        goto_edge(31);
        irq_ack = 2'b00;
        n_tests++; if (irq_pend !== 2'b11) begin n_fail++; $display("FAIL collide_pend@31: got %b expected 11", irq_pend); end
        n_tests++; if (irq_ovr !== 2'b00)  begin n_fail++; $display("FAIL collide_ovr@31: got %b expected 00", irq_ovr); end
    endtask

    task automatic test_overrun_ack();
        goto_edge(36);
        n_tests++; if (irq_ovr !== 2'b10)  begin n_fail++; $display("FAIL ovr@36: got %b expected 10", irq_ovr); end
        goto_edge(37);
        n_tests++; if (irq_ovr !== 2'b11)  begin n_fail++; $display("FAIL ovr@37: got %b expected 11", irq_ovr); end
        irq_ack = 2'b01;
        goto_edge(38);
        irq_ack = 2'b00;
        n_tests++; if (irq_pend !== 2'b10) begin n_fail++; $display("FAIL ack0_pend@38: got %b expected 10", irq_pend); end
        n_tests++; if (irq_ovr !== 2'b10)  begin n_fail++; $display("FAIL ack0_ovr@38: got %b expected 10", irq_ovr); end
        n_tests++; if (sys_irq !== 1'b1)   begin n_fail++; $display("FAIL ack0_lag@38: got %b expected 1", sys_irq); end
        goto_edge(39);
        n_tests++; if (sys_irq !== 1'b0)   begin n_fail++; $display("FAIL ack0_irq@39: got %b expected 0", sys_irq); end
        irq_ack = 2'b10;
        goto_edge(40);
        irq_ack = 2'b00;
        n_tests++; if (irq_pend !== 2'b00) begin n_fail++; $display("FAIL ack1_pend@40: got %b expected 00", irq_pend); end
        n_tests++; if (irq_ovr !== 2'b00)  begin n_fail++; $display("FAIL ack1_ovr@40: got %b expected 00", irq_ovr); end
    endtask

    // Soft reset accepted at edge 47; rises at 51,57,63,69 release sys_res at 69.
    task automatic test_soft_rst();
        goto_edge(46);
        n_tests++; if (irq_pend !== 2'b11) begin n_fail++; $display("FAIL pre_soft_pend@46: got %b expected 11", irq_pend); end
        n_tests++; if (irq_ovr !== 2'b10)  begin n_fail++; $display("FAIL pre_soft_ovr@46: got %b expected 10", irq_ovr); end
        soft_rst = 1'b1;
        goto_edge(47);
        soft_rst = 1'b0;
        n_tests++; if (sys_res !== 1'b1)   begin n_fail++; $display("FAIL soft_res@47: got %b expected 1", sys_res); end
        n_tests++; if (irq_pend !== 2'b00) begin n_fail++; $display("FAIL soft_pend@47: got %b expected 00", irq_pend); end
        n_tests++; if (irq_ovr !== 2'b00)  begin n_fail++; $display("FAIL soft_ovr@47: got %b expected 00", irq_ovr); end
        goto_edge(54);
        soft_rst = 1'b1;
        goto_edge(55);
        soft_rst = 1'b0;
        irq_mask = 2'b11;
        goto_edge(68);
        n_tests++; if (sys_res !== 1'b1)   begin n_fail++; $display("FAIL soft_hold@68: got %b expected 1", sys_res); end
        n_tests++; if (irq_pend !== 2'b00) begin n_fail++; $display("FAIL soft_tmr_held@68: got %b expected 00", irq_pend); end
        goto_edge(69);
        n_tests++; if (sys_res !== 1'b0)   begin n_fail++; $display("FAIL soft_release@69: got %b expected 0", sys_res); end
        goto_edge(74);
        n_tests++; if (irq_pend !== 2'b10) begin n_fail++; $display("FAIL post_soft_pend@74: got %b expected 10", irq_pend); end
        goto_edge(75);
        n_tests++; if (sys_irq !== 1'b1)   begin n_fail++; $display("FAIL post_soft_irq@75: got %b expected 1", sys_irq); end
    endtask

    task automatic test_async_reset();
        goto_edge(76);
        n_tests++; if (sys_clk !== 1'b1)   begin n_fail++; $display("FAIL pre_drop_clk@76: got %b expected 1", sys_clk); end
        #3;
        b_reset = 1'b0;
        #1;
        n_tests++; if (sys_clk !== 1'b0)   begin n_fail++; $display("FAIL async_clk: got %b expected 0", sys_clk); end
        n_tests++; if (sys_res !== 1'b1)   begin n_fail++; $display("FAIL async_res: got %b expected 1", sys_res); end
        n_tests++; if (irq_pend !== 2'b00) begin n_fail++; $display("FAIL async_pend: got %b expected 00", irq_pend); end
        n_tests++; if (sys_irq !== 1'b0)   begin n_fail++; $display("FAIL async_irq: got %b expected 0", sys_irq); end
        step();
        test_release_seq(10);
        #3;
        b_reset = 1'b0;
        #1;
        n_tests++; if (sys_clk !== 1'b0)      begin n_fail++; $display("FAIL count_drop_clk: got %b expected 0", sys_clk); end
        n_tests++; if (sys_clk_rise !== 1'b0) begin n_fail++; $display("FAIL count_drop_rise: got %b expected 0", sys_clk_rise); end
        n_tests++; if (sys_res !== 1'b1)      begin n_fail++; $display("FAIL count_drop_res: got %b expected 1", sys_res); end
        n_tests++; if (led_pow_h !== 1'b0)    begin n_fail++; $display("FAIL count_drop_led_h: got %b expected 0", led_pow_h); end
        n_tests++; if (led_pow_l !== 1'b1)    begin n_fail++; $display("FAIL count_drop_led_l: got %b expected 1", led_pow_l); end
        step();
    endtask

    initial begin
        test_reset();
        test_release_seq(22);
        test_irq();
        test_ack_tick_collision();
        test_overrun_ack();
        test_soft_rst();
        test_async_reset();
        test_release_seq(8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
